// File: rtl/aes_pkg.sv
// Shared constants, state encoding and word-select helper for the AES input serializer.
package aes_pkg;

    localparam int AES_BLOCK_W = 128;
    localparam int AES_BEATS   = 4;
    localparam int AES_WORD_W  = AES_BLOCK_W / AES_BEATS;

    localparam logic [1:0] AES_LAST_BEAT = 2'(AES_BEATS - 1);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        SEND        = 2'd1,
        WAIT_RESULT = 2'd2,
        DRAIN       = 2'd3
    } aes_ser_state_t;

    // Word 0 is the most significant 32 bits of the block.
    function automatic logic [AES_WORD_W-1:0] block_word(
        input logic [AES_BLOCK_W-1:0] blk,
        input logic [1:0]             idx
    );
        logic [AES_WORD_W-1:0] w;
        case (idx)
            2'd0:    w = blk[127:96];
            2'd1:    w = blk[95:64];
            2'd2:    w = blk[63:32];
            default: w = blk[31:0];
        endcase
        return w;
    endfunction

endpackage

// File: rtl/aes_in_serializer.sv
// Feeds AES128_core: takes one 128-bit plaintext/key block, emits four 32-bit beats, then waits for the core's 4-beat result burst.
// Optional result-wait watchdog enabled by defining AES_IN_TIMEOUT_EN.
module aes_in_serializer
    import aes_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   blk_valid_in,
    output logic                   blk_ready_out,
    input  logic [AES_BLOCK_W-1:0] blk_plaintext_in,
    input  logic [AES_BLOCK_W-1:0] blk_key_in,
    output logic                   MP_dv_out,
    output logic [DATA_WIDTH-1:0]  plaintext_out,
    output logic [DATA_WIDTH-1:0]  key_out,
    input  logic                   core_dv_in,
    output logic                   busy_out,
    output logic                   timeout_err_out
);

    // Handshake: a block transfers on a rising edge where blk_valid_in && blk_ready_out;
    // ready is high only in IDLE, and upstream must hold valid/data until then.

    aes_ser_state_t           state;
    aes_ser_state_t           state_next;
    logic [1:0]               beat_cnt;
    logic [1:0]               res_cnt;
    logic [AES_BLOCK_W-1:0]   pt_q;
    logic [AES_BLOCK_W-1:0]   key_q;
    logic                     accept;
    logic                     res_last;
    logic                     tmo_hit;

    assign accept   = (state == IDLE) && blk_valid_in;
    assign res_last = (state == DRAIN) && core_dv_in && (res_cnt == AES_LAST_BEAT);

`ifdef AES_IN_TIMEOUT_EN
    localparam logic [9:0] TMO_LAST = 10'(TIMEOUT_CYCLES - 1);

    logic [9:0] tmo_cnt;
    logic       tmo_err;

    assign tmo_hit = (state == WAIT_RESULT) && !core_dv_in && (tmo_cnt == TMO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
            tmo_err <= 1'b0;
        end else begin
            if ((state == WAIT_RESULT) && !core_dv_in && !tmo_hit)
                tmo_cnt <= tmo_cnt + 10'd1;
            else
                tmo_cnt <= '0;
            if (accept)
                tmo_err <= 1'b0;
            else if (tmo_hit)
                tmo_err <= 1'b1;
        end
    end

    assign timeout_err_out = tmo_err;
`else
    logic unused_timeout;
    assign unused_timeout  = (TIMEOUT_CYCLES > 0);
    assign tmo_hit         = 1'b0;
    assign timeout_err_out = 1'b0;
`endif

    always_comb begin
        state_next = state;
        case (state)
            IDLE:        if (blk_valid_in)              state_next = SEND;
            SEND:        if (beat_cnt == AES_LAST_BEAT) state_next = WAIT_RESULT;
            WAIT_RESULT: begin
                if (core_dv_in)   state_next = DRAIN;
                else if (tmo_hit) state_next = IDLE;
            end
            DRAIN:       if (res_last)                  state_next = IDLE;
            default:                                    state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            beat_cnt <= '0;
            res_cnt  <= '0;
            pt_q     <= '0;
            key_q    <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                pt_q  <= blk_plaintext_in;
                key_q <= blk_key_in;
            end
            if (state == SEND)
                beat_cnt <= beat_cnt + 2'd1;
            else
                beat_cnt <= '0;
            // The beat that moves WAIT_RESULT to DRAIN is result beat 0.
            if ((state == WAIT_RESULT) && core_dv_in)
                res_cnt <= 2'd1;
            else if ((state == DRAIN) && core_dv_in)
                res_cnt <= res_cnt + 2'd1;
            else if (state != DRAIN)
                res_cnt <= '0;
        end
    end

    assign blk_ready_out = (state == IDLE);
    assign busy_out      = (state != IDLE);
    assign MP_dv_out     = (state == SEND);
    assign plaintext_out = MP_dv_out ? block_word(pt_q, beat_cnt)  : '0;
    assign key_out       = MP_dv_out ? block_word(key_q, beat_cnt) : '0;

endmodule

// File: tb/tb_aes_in_serializer.sv
// Randomized scoreboard bench for aes_in_serializer: beats checked by a monitor, handshake timing by the drivers.
// Define AES_IN_TIMEOUT_EN to also exercise the watchdog with TIMEOUT_CYCLES=16.
module tb_aes_in_serializer;

`ifdef AES_IN_TIMEOUT_EN
    localparam int TB_TIMEOUT = 16;
`else
    localparam int TB_TIMEOUT = 64;
`endif

    logic         clk;
    logic         rst_n;
    logic         blk_valid_in;
    logic         blk_ready_out;
    logic [127:0] blk_plaintext_in;
    logic [127:0] blk_key_in;
    logic         MP_dv_out;
    logic [31:0]  plaintext_out;
    logic [31:0]  key_out;
    logic         core_dv_in;
    logic         busy_out;
    logic         timeout_err_out;

    int checks   = 0;
    int failures = 0;

    logic [63:0] exp_q[$];

    aes_in_serializer #(
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (TB_TIMEOUT)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .blk_valid_in     (blk_valid_in),
        .blk_ready_out    (blk_ready_out),
        .blk_plaintext_in (blk_plaintext_in),
        .blk_key_in       (blk_key_in),
        .MP_dv_out        (MP_dv_out),
        .plaintext_out    (plaintext_out),
        .key_out          (key_out),
        .core_dv_in       (core_dv_in),
        .busy_out         (busy_out),
        .timeout_err_out  (timeout_err_out)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        logic [63:0] e;
        check("busy_is_not_ready", busy_out, !blk_ready_out);
        if (MP_dv_out) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_beat: got %0h expected no beat at %0t",
                         {plaintext_out, key_out}, $time);
            end else begin
                e = exp_q.pop_front();
                check("beat_data", {plaintext_out, key_out}, e);
            end
        end else begin
            check("outputs_zero_when_invalid", {plaintext_out, key_out}, 128'd0);
        end
    end

    // ---------------- drivers ----------------
    // Offer a block upstream and record the four beats the core should see for it.
    task automatic present(input logic [127:0] pt, input logic [127:0] key);
        blk_valid_in     = 1'b1;
        blk_plaintext_in = pt;
        blk_key_in       = key;
        for (int i = 0; i < 4; i++)
            exp_q.push_back({pt[127-32*i -: 32], key[127-32*i -: 32]});
    endtask

    // Called at a negedge with the DUT idle; returns at the first WAIT_RESULT negedge.
    task automatic send_block(input logic [127:0] pt, input logic [127:0] key, input bit presented,
                              input bit spur, input bit chain,
                              input logic [127:0] npt, input logic [127:0] nkey);
        check("ready_before_accept", blk_ready_out, 1'b1);
        if (!presented) present(pt, key);
        core_dv_in = spur;
        @(negedge clk);
        check("mp_dv_first_after_accept", MP_dv_out, 1'b1);
        check("ready_low_in_send", blk_ready_out, 1'b0);
        check("err_clear_after_accept", timeout_err_out, 1'b0);
        if (chain) begin
            present(npt, nkey);
        end else begin
            blk_valid_in     = 1'b0;
            blk_plaintext_in = rand128();
            blk_key_in       = rand128();
        end
        for (int b = 1; b < 4; b++) begin
            core_dv_in = spur && (b == 2);
            @(negedge clk);
            check("mp_dv_held_in_send", MP_dv_out, 1'b1);
        end
        core_dv_in = 1'b0;
        @(negedge clk);
        check("mp_dv_low_after_4", MP_dv_out, 1'b0);
        check("beats_consumed", exp_q.size(), chain ? 4 : 0);
        check("ready_low_in_wait", blk_ready_out, 1'b0);
    endtask

    // mode 0: back-to-back beats; 1: pattern 1,1,0,1,1; 2: random gaps after the first beat.
    task automatic result_burst(input int lat, input int mode);
        logic pat [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        int   hi = 0;
        int   n  = 0;
        for (int i = 0; i < lat; i++) begin
            check("busy_during_latency", busy_out, 1'b1);
            @(negedge clk);
        end
        while (hi < 4) begin
            case (mode)
                0:       core_dv_in = 1'b1;
                1:       core_dv_in = pat[n % 5];
                default: core_dv_in = (hi == 0 || n >= 40) ? 1'b1 : 1'($urandom_range(0, 1));
            endcase
            if (core_dv_in) hi++;
            n++;
            @(negedge clk);
            if (hi < 4)
                check("ready_low_until_4th_result", blk_ready_out, 1'b0);
            else
                check("ready_after_4th_result", blk_ready_out, 1'b1);
        end
        core_dv_in = 1'b0;
    endtask

    task automatic run_block(input logic [127:0] pt, input logic [127:0] key, input bit presented,
                             input int lat, input int mode, input bit spur, input bit chain,
                             input logic [127:0] npt, input logic [127:0] nkey);
        send_block(pt, key, presented, spur, chain, npt, nkey);
        result_burst(lat, mode);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [127:0] pa, ka, pb, kb;

        rst_n            = 1'b0;
        blk_valid_in     = 1'b0;
        blk_plaintext_in = '0;
        blk_key_in       = '0;
        core_dv_in       = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_ready", blk_ready_out, 1'b1);
        check("reset_busy", busy_out, 1'b0);
        check("reset_mp_dv", MP_dv_out, 1'b0);
        check("reset_err", timeout_err_out, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // Known vector
        run_block(128'h41647661_6E636564_20456E63_72797074,
                  128'h54686174_73204D79_204B756E_67204675,
                  1'b0, 3, 0, 1'b0, 1'b0, '0, '0);

        // Spurious core_dv_in while idle
        core_dv_in = 1'b1;
        repeat (2) @(negedge clk);
        core_dv_in = 1'b0;
        check("idle_ignores_core_dv", blk_ready_out, 1'b1);

        // Gapped result pattern, then spurious pulses in IDLE/SEND
        run_block(rand128(), rand128(), 1'b0, 2, 1, 1'b0, 1'b0, '0, '0);
        run_block(rand128(), rand128(), 1'b0, 1, 0, 1'b1, 1'b0, '0, '0);

        // Back-to-back with valid held high
        pa = rand128(); ka = rand128(); pb = rand128(); kb = rand128();
        run_block(pa, ka, 1'b0, 4, 2, 1'b0, 1'b1, pb, kb);
        run_block(pb, kb, 1'b1, 0, 0, 1'b0, 1'b0, '0, '0);

        // Randomized blocks
        for (int k = 0; k < 8; k++)
            run_block(rand128(), rand128(), 1'b0, $urandom_range(0, 6), $urandom_range(0, 2),
                      1'($urandom_range(0, 1)), 1'b0, '0, '0);

        // Reset in the middle of SEND, right after beat 1
        present(rand128(), rand128());
        @(negedge clk);
        blk_valid_in = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_send_mp_dv", MP_dv_out, 1'b0);
        check("rst_mid_send_data", {plaintext_out, key_out}, 128'd0);
        check("rst_mid_send_ready", blk_ready_out, 1'b1);
        check("rst_mid_send_busy", busy_out, 1'b0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("no_beats_after_abort", MP_dv_out, 1'b0);
        end

`ifdef AES_IN_TIMEOUT_EN
        send_block(rand128(), rand128(), 1'b0, 1'b0, 1'b0, '0, '0);
        for (int c = 0; c < TB_TIMEOUT; c++) begin
            check("no_err_before_timeout", timeout_err_out, 1'b0);
            check("busy_before_timeout", busy_out, 1'b1);
            @(negedge clk);
        end
        check("err_set_on_timeout", timeout_err_out, 1'b1);
        check("idle_after_timeout", blk_ready_out, 1'b1);
        @(negedge clk);
        check("err_sticky", timeout_err_out, 1'b1);
`endif

        // Recovery block after abort / timeout
        run_block(rand128(), rand128(), 1'b0, 2, 2, 1'b0, 1'b0, '0, '0);

        repeat (2) @(negedge clk);
        check("exp_q_empty_at_end", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/aes_in_serializer.md
AES_IN_SERIALIZER -- requirements
Module: aes_in_serializer

Purpose: upstream feeder for AES128_core. Accepts one 128-bit plaintext/key block via valid/ready, emits it as four 32-bit beats on the core's MP_dv_in/plaintext_in/key_in inputs, then holds off until the core's four-beat result burst on core_dv_out has completed.

Interface
REQ-001 Parameter: DATA_WIDTH, 32, beat width; only 32 is supported.
REQ-002 Parameter: TIMEOUT_CYCLES, 64, result-wait watchdog limit in cycles; range 1..1023.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 blk_valid_in  input  1  upstream block valid.
REQ-006 blk_ready_out  output  1  serializer can accept a block.
REQ-007 blk_plaintext_in  input  128  plaintext block; bits [127:96] are the first word.
REQ-008 blk_key_in  input  128  key block; same word order.
REQ-009 MP_dv_out  output  1  beat valid; drives core MP_dv_in.
REQ-010 plaintext_out  output  DATA_WIDTH  plaintext beat; drives core plaintext_in.
REQ-011 key_out  output  DATA_WIDTH  key beat; drives core key_in.
REQ-012 core_dv_in  input  1  core result-beat valid (core_dv_out).
REQ-013 busy_out  output  1  high whenever state is not IDLE.
REQ-014 timeout_err_out  output  1  sticky watchdog flag.

Function
REQ-015 FSM states SHALL be IDLE, SEND, WAIT_RESULT, DRAIN.
REQ-016 blk_ready_out SHALL be high exactly when state is IDLE; a block is accepted on a rising edge with blk_valid_in && blk_ready_out.
REQ-017 On accept, both 128-bit blocks SHALL be latched, beat 0 presented, and state SHALL become SEND.
REQ-018 MP_dv_out SHALL be high for exactly 4 consecutive cycles, starting the cycle after accept, with words [127:96], [95:64], [63:32], [31:0] in that order.
REQ-019 plaintext_out and key_out SHALL be 0 whenever MP_dv_out is low.
REQ-020 After beat 3, state SHALL become WAIT_RESULT; core_dv_in in IDLE or SEND SHALL be ignored.
REQ-021 In WAIT_RESULT, the first cycle with core_dv_in high SHALL count as result beat 0 and move to DRAIN.
REQ-022 DRAIN SHALL count cycles with core_dv_in high; after the 4th counted beat the FSM SHALL return to IDLE (blk_ready_out high the next cycle). Low cycles are not counted.
REQ-023 blk_valid_in while not IDLE SHALL have no effect; the upstream holds its data.
REQ-024 The minimum block-to-block spacing SHALL be 4 send cycles + core latency + 4 result beats + 1 cycle.

Reset
REQ-025 While rst_n is low: state IDLE, beat and result counters 0, MP_dv_out 0, plaintext_out 0, key_out 0, busy_out 0, timeout_err_out 0, blk_ready_out 1.
REQ-026 Reset asserted mid-SEND or mid-DRAIN SHALL abort the block immediately with no further beats.

Configuration
REQ-027 Macro AES_IN_TIMEOUT_EN defined: a counter runs in WAIT_RESULT. If it reaches TIMEOUT_CYCLES without core_dv_in, the FSM SHALL go to IDLE and set timeout_err_out.
REQ-028 timeout_err_out SHALL clear on the next accepted block.
REQ-029 Macro not defined: no counter is built; WAIT_RESULT waits indefinitely; timeout_err_out is tied to 0. The port list is identical in both builds.

Structure
REQ-030 Package aes_pkg SHALL hold AES_BLOCK_W=128, AES_BEATS=4, and the state enum typedef aes_ser_state_t.
REQ-031 The module SHALL be self-contained; no sub-module is required.

Verification
REQ-032 Single block: plaintext 41647661_6E636564_20456E63_72797074, key 54686174_73204D79_204B756E_67204675 -> four beats in that word order. When chained to AES128_core, the result is 6f5ddb7f39560b0fe9eada49f87c4904.
REQ-033 Back-to-back: blk_valid_in held high with two blocks -> the second is accepted only on the edge after the 4th core_dv_in beat; blk_ready_out is low throughout.
REQ-034 Gapped result: core_dv_in pattern 1,1,0,1,1 -> IDLE only after the 4th high beat.
REQ-035 Reset mid-SEND after beat 1 -> MP_dv_out drops at once, all outputs 0, blk_ready_out 1.
REQ-036 AES_IN_TIMEOUT_EN with TIMEOUT_CYCLES=16 and core_dv_in held 0 -> timeout_err_out rises 16 cycles into WAIT_RESULT, FSM returns to IDLE, and the flag clears on the next accept.
REQ-037 Spurious core_dv_in pulse in IDLE or SEND -> no state change and no beat miscount.
